// File: rtl/digit_scan_display.sv
// Captures an 8-bit value, converts it to BCD by double-dabble, and scans it
// onto a 4-digit multiplexed 7-segment display along with a hex capture count.
module digit_scan_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

  state_e        state_q, state_d;
  logic [7:0]    bin_q, bin_d;
  logic [11:0]   bcd_q, bcd_d, bcd_adj;
  logic [2:0]    iter_q, iter_d;
  logic [3:0]    hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          wrap;
  logic [3:0]    digit;
  logic          blank;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: seg_code = 7'b1000000;
      4'h1: seg_code = 7'b1111001;
      4'h2: seg_code = 7'b0100100;
      4'h3: seg_code = 7'b0110000;
      4'h4: seg_code = 7'b0011001;
      4'h5: seg_code = 7'b0010010;
      4'h6: seg_code = 7'b0000010;
      4'h7: seg_code = 7'b1111000;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0010000;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b0000011;
      4'hC: seg_code = 7'b1000110;
      4'hD: seg_code = 7'b0100001;
      4'hE: seg_code = 7'b0000110;
      default: seg_code = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          bin_d   = data_in;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        // Top BCD bit is always 0 for an 8-bit input, so it is shifted out.
        {bcd_d, bin_d} = 20'({bcd_adj, bin_q, 1'b0});
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = LOAD;
      end
      LOAD: begin
        hund_d  = bcd_q[11:8];
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        cnt_d   = cnt_q + 4'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    wrap  = (ref_q == RW'(REFRESH_DIV - 1));
    ref_d = wrap ? '0 : ref_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    digit = ones_q;
    blank = 1'b0;
    case (idx_q)
      2'd0: digit = ones_q;
      2'd1: begin
        digit = tens_q;
        blank = (hund_q == 4'd0) && (tens_q == 4'd0);
      end
      2'd2: begin
        digit = hund_q;
        blank = (hund_q == 4'd0);
      end
      default: digit = cnt_q;
    endcase
    seg_d = blank ? '1 : seg_code(digit);
    an_d  = ~(4'b0001 << idx_q);
    dp_d  = (idx_q != 2'd3);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '1;
      an_q    <= '1;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign busy = busy_q;
  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_digit_scan_display.sv
// Randomized bench: a decimal/edge-count model predicts busy, seg, an and dp after every edge.
module tb_digit_scan_display;

  localparam int unsigned DIV = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int tests = 0;
  int errors = 0;

  // Model state: edges since reset release, last capture edge, displayed value and count.
  int k, cap_edge, pend_val, shown_val, shown_cnt;
  bit have_cap, pend;

  logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  digit_scan_display #(.REFRESH_DIV(DIV)) dut (
    .Clk(Clk), .Rst(Rst), .data_in(data_in), .data_valid(data_valid),
    .busy(busy), .seg(seg), .an(an), .dp(dp)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; have_cap = 0; pend = 0; shown_val = 0; shown_cnt = 0; cap_edge = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_seg"},  32'(seg),  32'h7F);
    check({tag, "_an"},   32'(an),   32'hF);
    check({tag, "_dp"},   32'(dp),   32'd1);
  endtask

  task automatic tick();
    int idx, d;
    bit blank;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    bit e_dp, e_busy;
    @(posedge Clk);
    if (!Rst) begin
      model_reset();
      #1;
      check_reset_outputs("rst");
    end else begin
      k++;
      idx = ((k - 1) / DIV) % 4;
      blank = 0;
      case (idx)
        0: d = shown_val % 10;
        1: begin d = (shown_val / 10) % 10; blank = (shown_val < 10); end
        2: begin d = shown_val / 100; blank = (shown_val < 100); end
        default: d = shown_cnt;
      endcase
      e_seg = blank ? 7'h7F : SEG[d];
      e_an  = 4'hF ^ 4'(1 << idx);
      e_dp  = (idx != 3);
      if (pend && k == cap_edge + 9) begin
        shown_val = pend_val;
        shown_cnt = (shown_cnt + 1) % 16;
        pend = 0;
      end
      if (data_valid && (!have_cap || k >= cap_edge + 10)) begin
        cap_edge = k; pend_val = int'(data_in); pend = 1; have_cap = 1;
      end
      e_busy = have_cap && (k <= cap_edge + 8);
      #1;
      check("busy", 32'(busy), 32'(e_busy));
      check("seg",  32'(seg),  32'(e_seg));
      check("an",   32'(an),   32'(e_an));
      check("dp",   32'(dp),   32'(e_dp));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [7:0] v, input int gap);
    data_in = v; data_valid = 1'b1;
    tick();
    data_valid = 1'b0; data_in = 8'($urandom);
    run(gap);
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    run(2);
    Rst = 1'b1;
  endtask

  initial begin
    data_in = '0; data_valid = 1'b0; Rst = 1'b1;
    model_reset();
    #2 Rst = 1'b0;
    #1 check_reset_outputs("init_rst");
    run(2);
    Rst = 1'b1;

    // First edge after release: ones digit "0" in slot 0.
    tick();
    check("first_an", 32'(an), 32'hE);
    check("first_seg", 32'(seg), 32'h40);
    run(19);

    pulse(8'd209, 30);
    pulse(8'd7, 20);
    pulse(8'd45, 20);
    pulse(8'd255, 20);

    // Continuous valid: only every 10th value is taken.
    data_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      data_in = 8'($urandom);
      tick();
    end
    data_valid = 1'b0;
    run(20);

    // 17 captures from a clean reset make the count wrap past F.
    do_reset();
    for (int i = 0; i < 17; i++) pulse(8'($urandom), 10 + int'($urandom_range(0, 3)));
    run(20);

    // Reset in the middle of a conversion.
    pulse(8'd123, 4);
    do_reset();
    run(20);

    for (int i = 0; i < 300; i++) begin
      data_valid = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      tick();
    end
    data_valid = 1'b0;
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
